// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the multi-port register file.
//   ra/rd/rd_busy : NRP packed read ports (addresses in, data and busy bits out)
//   we0/wa0/wd0   : write port 0 (lower priority)
//   we1/wa1/wd1   : write port 1 (higher priority)
//   sb_set/sb_wa  : scoreboard busy-set request
//   ready         : init sweep finished
// master = pipeline side (decode + writeback), slave = register file.
interface regfile_mp_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRP  = 2
);
    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd;
    logic [NRP-1:0]      rd_busy;
    logic                we0;
    logic [AW-1:0]       wa0;
    logic [XLEN-1:0]     wd0;
    logic                we1;
    logic [AW-1:0]       wa1;
    logic [XLEN-1:0]     wd1;
    logic                sb_set;
    logic [AW-1:0]       sb_wa;
    logic                ready;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_wa,
        input  rd, rd_busy, ready
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_wa,
        output rd, rd_busy, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NRP-read / 2-write integer register file with busy scoreboard
// and a post-reset init sweep (stack pointer preset).
//   clk : clock, rising edge
//   rst : synchronous active-high reset; restarts the init sweep
//   bus : regfile_mp_if slave port (reads, writes, scoreboard set, ready)
module regfile_mp #(
    parameter int unsigned     XLEN    = 64,
    parameter int unsigned     NREG    = 32,
    parameter int unsigned     NRP     = 2,
    parameter int unsigned     SP_IDX  = 2,
    parameter longint unsigned SP_INIT = 16,
    parameter bit              BYPASS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_ptr;
    logic [XLEN-1:0] r_regarr [NREG];
    logic [NREG-1:0] r_sb;
    logic [NREG-1:0] w_sb_nxt;
    logic            w_run;
    logic            w_last;

    assign w_run     = (r_state == S_RUN);
    assign w_last    = (r_ptr == AW'(NREG - 1));
    assign bus.ready = w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_ptr <= r_ptr + AW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && w_last) begin
            w_state_nxt = S_RUN;
        end
    end

    // No reset on the array itself: the sweep is what initialises it.
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_INIT) begin
                r_regarr[r_ptr] <= (r_ptr == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
            end else begin
                if (bus.we0 && bus.wa0 != '0) begin
                    r_regarr[bus.wa0] <= bus.wd0;
                end
                if (bus.we1 && bus.wa1 != '0) begin
                    r_regarr[bus.wa1] <= bus.wd1;
                end
            end
        end
    end

    // Clear on commit first, then set, so a same-cycle set wins.
    always_comb begin
        w_sb_nxt = r_sb;
        if (w_run) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if ((bus.we0 && bus.wa0 == AW'(r)) || (bus.we1 && bus.wa1 == AW'(r))) begin
                    w_sb_nxt[r] = 1'b0;
                end
                if (bus.sb_set && bus.sb_wa == AW'(r)) begin
                    w_sb_nxt[r] = 1'b1;
                end
            end
        end
        w_sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    for (genvar g = 0; g < NRP; g++) begin : g_rport
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = bus.ra[g*AW +: AW];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run && w_addr != '0) begin
                w_data = r_regarr[w_addr];
                if (BYPASS && bus.we0 && bus.wa0 == w_addr) begin
                    w_data = bus.wd0;
                end
                if (BYPASS && bus.we1 && bus.wa1 == w_addr) begin
                    w_data = bus.wd1;
                end
                w_busy = r_sb[w_addr];
            end
        end

        assign bus.rd[g*XLEN +: XLEN] = w_data;
        assign bus.rd_busy[g]         = w_busy;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the pipelined successor of the 64-bit RISC-V core. It has NRP combinational read ports with optional same-cycle write bypass and two write ports with fixed priority. A per-register busy scoreboard drives hazard detection. After reset, a sweep state machine initialises every register, presetting the stack pointer, and raises ready when done. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- XLEN, 64, data width in bits.
- NREG, 32, number of registers; power of two, at least 4.
- AW, $clog2(NREG), address width (derived, not overridden).
- NRP, 2, number of read ports, 1 to 8.
- SP_IDX, 2, index of the register preset during init.
- SP_INIT, 16, value loaded into register SP_IDX during init.
- BYPASS, 1, 1 = write data forwarded to read ports in the same cycle; 0 = array value only.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- ra  in  NRP*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRP*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NRP  scoreboard busy bit of the register addressed by each read port.
- we0, wa0, wd0  in  1, AW, XLEN  write port 0 (lower priority).
- we1, wa1, wd1  in  1, AW, XLEN  write port 1 (higher priority).
- sb_set  in  1  mark register sb_wa busy (issue of an instruction that writes it).
- sb_wa  in  AW  scoreboard set address.
- ready  out  1  1 = init sweep complete and file accepting writes.

## Operation
- States: INIT, RUN.
- rst=1: next state INIT; sweep pointer ptr <= 0; ready <= 0; all scoreboard bits <= 0.
  - rst overrides everything, including a sweep already in progress; the sweep restarts from 0.
- INIT, one register per cycle: regarr[ptr] <= (ptr==SP_IDX) ? SP_INIT : 0; ptr <= ptr+1.
  - When ptr==NREG-1: write that last entry, go to RUN, ready <= 1.
- INIT is a closed window: we0, we1 and sb_set are ignored; rd and rd_busy read as all zero.
- RUN, write ports: we0 with wa0!=0 writes wd0; we1 with wa1!=0 writes wd1.
  - wa0==wa1 with both enabled: only wd1 is stored.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Read data (combinational), for each port i in RUN, in priority order:
  - ra_i==0 gives 0.
  - Else, if BYPASS and we1 && wa1==ra_i, gives wd1.
  - Else, if BYPASS and we0 && wa0==ra_i, gives wd0.
  - Else gives regarr[ra_i].
- Scoreboard, for each register r!=0 in RUN:
  - A write commit (we0/we1 to r) clears sb[r].
  - sb_set with sb_wa==r sets sb[r]; a set wins over a clear of the same register in the same cycle.
  - sb_set to register 0 is ignored; sb[0] is constant 0.
- rd_busy[i] = sb[ra_i], combinational. It reflects stored scoreboard state only and does not bypass a same-cycle clear.

## Timing
- Reset values:
  - ready=0 while rst is high and during INIT; rd=0; rd_busy=0.
  - Array contents are undefined until the sweep writes them.
- Init latency: rst falls before edge E0. Sweeps happen at E0 through E(NREG-1). ready reads 1 after edge E(NREG-1), i.e. NREG cycles after reset release.
- Write latency:
  - Stored at the rising edge where the enable is high; read from the array from the next cycle on.
  - With BYPASS=1, also visible on rd in the enable cycle itself.
- Read latency: zero cycles (combinational from ra and the write ports).
- Scoreboard latency: set or clear takes effect after the edge; rd_busy changes the next cycle.
- A write port enabled in the same cycle that INIT ends (ptr==NREG-1) is ignored.

## Test plan
- Init sweep:
  - Stimulus: rst high 2 cycles, release, NREG=32.
  - Required: ready=0 for 32 cycles, then 1. Reading x2 returns 16; x1, x3 and x31 return 0.
- Write/read and x0:
  - Stimulus: in RUN, we0 wa0=5 wd0=0xDEAD_BEEF_0000_0001; next cycle ra0=5. Then we0 wa0=0 wd0=0xFF.
  - Required: rd port0 returns 0xDEAD_BEEF_0000_0001. ra0=0 always returns 0.
- Dual-write collision and bypass:
  - Stimulus: we0 wa0=7 wd0=0x11 and we1 wa1=7 wd1=0x22 with ra1=7 in the same cycle.
  - Required, same cycle: rd port1=0x22 with BYPASS=1; with BYPASS=0 it shows the old value.
  - Required, next cycle: 0x22.
- Scoreboard:
  - Stimulus: sb_set sb_wa=9; then ra0=9; then we1 wa1=9 with sb_set sb_wa=9 in the same cycle; then a write to 9 alone.
  - Required: rd_busy[0]=1 after the set; stays 1 after the simultaneous write+set; 0 after the lone write. sb_set to x0 never makes busy=1.
- Reset mid-operation:
  - Stimulus: rst asserted at sweep step 10. Separately, rst asserted in RUN after writing x5=0x55.
  - Required: both restart the sweep from 0 with ready=0 for a full 32 cycles; x5 reads 0 afterwards; all busy bits are 0.
- INIT lockout:
  - Stimulus: we1 wa1=4 wd1=0x99 and sb_set sb_wa=4 during INIT.
  - Required: after ready, x4 reads 0 and rd_busy for x4 is 0.
